regf_write_ctrl: RTL and testbench
==================================

# regf_write_ctrl

Write-port controller for the 32x32 register file. It owns the file's single write port (`we3`/`a3`/`wd3`) and is the write-side counterpart to the file's read ports. After reset it clears x1..x31 one register per cycle while stalling the core. It then passes core writeback through and merges a buffered debug-write channel with a valid/ready handshake, a completion response and a starvation guard.

## Interface
- `XLEN`, 32, data width
- `AW`, 5, register address width
- `STARVE_MAX`, 8, cycles a pending debug write may wait before the core is stalled to drain it (≥1)

- `clk`  in  1  clock, all state on rising edge
- `rst_n`  in  1  reset, synchronous, active-low
- `core_we`  in  1  core writeback enable
- `core_a3`  in  AW  core writeback address
- `core_wd3`  in  XLEN  core writeback data
- `core_stall`  out  1  core must hold state; its write is ignored this cycle
- `init_done`  out  1  high once clearing is complete
- `dbg_valid`  in  1  debug write request
- `dbg_ready`  out  1  debug write accepted when both high
- `dbg_addr`  in  AW  debug write address
- `dbg_data`  in  XLEN  debug write data
- `dbg_resp_valid`  out  1  one-cycle completion pulse
- `dbg_resp_err`  out  1  qualifies the response: 1 = write dropped
- `rf_we3`, `rf_a3`, `rf_wd3`  out  1/AW/XLEN  to register file write port

## Operation
- States: ST_INIT and ST_RUN.
- Reset (`rst_n` low at an edge): ST_INIT, clear index = 1, buffer empty, starvation counter = 0, response regs = 0.
- ST_INIT:
  - `rf_we3`=1, `rf_a3`=index, `rf_wd3`=0; index increments each cycle.
  - After writing index 31, go to ST_RUN.
  - `core_stall`=1, `dbg_ready`=0, `init_done`=0 throughout.
  - x0 is never written.
- ST_RUN, no drain this cycle: `rf_we3` = `core_we` && `core_a3`!=0, with `rf_a3`/`rf_wd3` taken from the core. This path is combinational and adds no latency.
- `dbg_ready` = ST_RUN && buffer empty. An accept captures addr/data into the one-entry buffer.
- Accepting `dbg_addr`==0: nothing is buffered; response err=1 on the next cycle.
- Drain cycle: buffer full and (core not writing, i.e. `core_we`=0 or `core_a3`=0, or forced).
  - Port driven from the buffer; buffer empties at the edge.
  - Response err=0 on the next cycle.
- Conflict: buffer full and core writes the same nonzero address → buffer discarded, core write proceeds, response err=1 next cycle (core write wins).
- Starvation:
  - Counter increments each cycle the buffer is full and not drained, and clears on drain or discard.
  - When the counter equals STARVE_MAX: `core_stall`=1, the core write is ignored, and the buffer drains that cycle.
- While `rst_n` is low, all outputs are forced: `rf_we3`=0, `core_stall`=1, `dbg_ready`=0, `dbg_resp_valid`=0, `dbg_resp_err`=0, `init_done`=0.

## Timing
- Clear sequence takes 31 cycles after reset release; `init_done` and ST_RUN begin on the 32nd cycle.
- Reset asserted mid-clear restarts the sequence at index 1.
- Reset asserted with a pending debug write: the write is lost and no response is issued.
- Debug latency: accept at edge N, earliest drain in cycle N+1, response in cycle N+2.
- Worst-case wait is STARVE_MAX stalled cycles plus the drain cycle.
- `dbg_resp_valid` is high exactly one cycle per accepted request; responses are in order.
- No accept can occur in the same cycle as a drain, because `dbg_ready` is low while the buffer is full.

## Configuration
- `REGF_DBG_EN` defined: debug buffer, starvation counter and response logic are built.
- `REGF_DBG_EN` undefined:
  - Ports remain; `dbg_ready`, `dbg_resp_valid` and `dbg_resp_err` are tied to 0.
  - `core_stall` = ST_INIT only; ST_RUN is pure core pass-through.

## Structure
- Package `regf_pkg` holds:
  - the state typedef (ST_INIT, ST_RUN)
  - `XLEN`, `AW` and `NREGS`=32 defaults
  - the first clear index constant (1)
- Sub-module `regf_dbg_buf`:
  - one-entry buffer, starvation counter, conflict detect and response register
  - instantiated only under `REGF_DBG_EN`

## Test plan
- Reset release → `rf_we3`=1 for 31 cycles with `rf_a3`=1..31 and `rf_wd3`=0; `init_done`=1 on cycle 32. Reset pulse at index 12 → sequence restarts at 1.
- ST_RUN, `core_we`=1, a3=5, wd3=0xDEADBEEF → same cycle `rf_we3`=1, a3=5. With a3=0 → `rf_we3`=0.
- Debug write addr=7, data=0x1234 with core idle → accept, drain next cycle, `dbg_resp_valid`=1 and err=0 the cycle after.
- Debug addr=9 accepted, core writes addr=9 next cycle → core data written, response err=1. Debug addr=0 → response err=1, no write.
- Core writes every cycle, STARVE_MAX=8, debug addr=3 accepted → `core_stall`=1 on the 9th cycle after accept, debug data written, response follows.
- Build without `REGF_DBG_EN` → `dbg_ready` held 0 for any `dbg_valid`; core pass-through unchanged.

Source files
------------

// File: rtl/regf_pkg.sv
// Shared types and defaults for the register-file write-port controller.
package regf_pkg;

    localparam int unsigned XLEN          = 32;
    localparam int unsigned AW            = 5;
    localparam int unsigned NREGS         = 32;
    localparam int unsigned FIRST_CLR_IDX = 1;

    typedef enum logic {
        ST_INIT,
        ST_RUN
    } regf_state_e;

endpackage

// File: rtl/regf_dbg_buf.sv
// One-entry debug write buffer with starvation counter, core-conflict detect
// and a registered completion response.
module regf_dbg_buf #(
    parameter int unsigned XLEN       = 32,
    parameter int unsigned AW         = 5,
    parameter int unsigned STARVE_MAX = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            run,
    input  logic            core_wr,
    input  logic [AW-1:0]   core_a3,
    input  logic            dbg_valid,
    input  logic [AW-1:0]   dbg_addr,
    input  logic [XLEN-1:0] dbg_data,
    output logic            dbg_ready,
    output logic            drain,
    output logic            force_stall,
    output logic [AW-1:0]   buf_addr,
    output logic [XLEN-1:0] buf_data,
    output logic            resp_valid,
    output logic            resp_err
);

    localparam int unsigned CW = $clog2(STARVE_MAX + 1);

    logic            full_q, full_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic [XLEN-1:0] data_q, data_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            resp_valid_q, resp_valid_d;
    logic            resp_err_q, resp_err_d;
    logic            accept, starve, conflict, addr_zero;

    assign dbg_ready   = run && !full_q;
    assign accept      = dbg_valid && dbg_ready;
    assign addr_zero   = (dbg_addr == '0);
    assign starve      = full_q && (cnt_q == CW'(STARVE_MAX));
    assign drain       = full_q && (!core_wr || starve);
    // A starving buffer wins over the core, so it never counts as a conflict.
    assign conflict    = full_q && !starve && core_wr && (core_a3 == addr_q);
    assign force_stall = starve;
    assign buf_addr    = addr_q;
    assign buf_data    = data_q;
    assign resp_valid  = resp_valid_q;
    assign resp_err    = resp_err_q;

    always_comb begin
        full_d = full_q;
        addr_d = addr_q;
        data_d = data_q;
        cnt_d  = cnt_q;
        if (drain || conflict) begin
            full_d = 1'b0;
            cnt_d  = '0;
        end else if (full_q) begin
            cnt_d = cnt_q + 1'b1;
        end
        if (accept && !addr_zero) begin
            full_d = 1'b1;
            addr_d = dbg_addr;
            data_d = dbg_data;
        end
        resp_valid_d = drain || conflict || (accept && addr_zero);
        resp_err_d   = conflict || (accept && addr_zero);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            full_q       <= 1'b0;
            addr_q       <= '0;
            data_q       <= '0;
            cnt_q        <= '0;
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
        end else begin
            full_q       <= full_d;
            addr_q       <= addr_d;
            data_q       <= data_d;
            cnt_q        <= cnt_d;
            resp_valid_q <= resp_valid_d;
            resp_err_q   <= resp_err_d;
        end
    end

endmodule

// File: rtl/regf_write_ctrl.sv
// Register-file write-port owner: post-reset clear of x1..x31, core writeback
// pass-through and, when REGF_DBG_EN is defined, a merged debug-write channel.
module regf_write_ctrl #(
    parameter int unsigned XLEN       = 32,
    parameter int unsigned AW         = 5,
    parameter int unsigned STARVE_MAX = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            core_we,
    input  logic [AW-1:0]   core_a3,
    input  logic [XLEN-1:0] core_wd3,
    output logic            core_stall,
    output logic            init_done,
    input  logic            dbg_valid,
    output logic            dbg_ready,
    input  logic [AW-1:0]   dbg_addr,
    input  logic [XLEN-1:0] dbg_data,
    output logic            dbg_resp_valid,
    output logic            dbg_resp_err,
    output logic            rf_we3,
    output logic [AW-1:0]   rf_a3,
    output logic [XLEN-1:0] rf_wd3
);

    import regf_pkg::*;

    localparam logic [AW-1:0] LAST_IDX = AW'(NREGS - 1);

    regf_state_e     state_q, state_d;
    logic [AW-1:0]   idx_q, idx_d;
    logic            core_wr, drain, force_stall;
    logic [AW-1:0]   buf_addr;
    logic [XLEN-1:0] buf_data;

    assign core_wr = core_we && (core_a3 != '0);

`ifdef REGF_DBG_EN
    logic buf_ready, buf_resp_valid, buf_resp_err;

    regf_dbg_buf #(
        .XLEN       (XLEN),
        .AW         (AW),
        .STARVE_MAX (STARVE_MAX)
    ) u_dbg_buf (
        .clk         (clk),
        .rst_n       (rst_n),
        .run         (state_q == ST_RUN),
        .core_wr     (core_wr),
        .core_a3     (core_a3),
        .dbg_valid   (dbg_valid),
        .dbg_addr    (dbg_addr),
        .dbg_data    (dbg_data),
        .dbg_ready   (buf_ready),
        .drain       (drain),
        .force_stall (force_stall),
        .buf_addr    (buf_addr),
        .buf_data    (buf_data),
        .resp_valid  (buf_resp_valid),
        .resp_err    (buf_resp_err)
    );

    assign dbg_ready      = rst_n && buf_ready;
    assign dbg_resp_valid = rst_n && buf_resp_valid;
    assign dbg_resp_err   = rst_n && buf_resp_err;
`else
    logic unused_dbg;
    assign unused_dbg     = ^{dbg_valid, dbg_addr, dbg_data};
    assign drain          = 1'b0;
    assign force_stall    = 1'b0;
    assign buf_addr       = '0;
    assign buf_data       = '0;
    assign dbg_ready      = 1'b0;
    assign dbg_resp_valid = 1'b0;
    assign dbg_resp_err   = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        if (state_q == ST_INIT) begin
            idx_d = idx_q + 1'b1;
            if (idx_q == LAST_IDX) begin
                state_d = ST_RUN;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_INIT;
            idx_q   <= AW'(FIRST_CLR_IDX);
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

    // Reset overrides everything so the port is quiet before the first edge.
    always_comb begin
        rf_we3     = 1'b0;
        rf_a3      = '0;
        rf_wd3     = '0;
        core_stall = 1'b1;
        init_done  = 1'b0;
        if (rst_n) begin
            if (state_q == ST_INIT) begin
                rf_we3 = 1'b1;
                rf_a3  = idx_q;
            end else begin
                init_done  = 1'b1;
                core_stall = force_stall;
                if (drain) begin
                    rf_we3 = 1'b1;
                    rf_a3  = buf_addr;
                    rf_wd3 = buf_data;
                end else begin
                    rf_we3 = core_wr;
                    rf_a3  = core_a3;
                    rf_wd3 = core_wd3;
                end
            end
        end
    end

endmodule

// File: tb/tb_regf_write_ctrl.sv
// Self-checking bench for regf_write_ctrl; debug-channel tests run only when
// REGF_DBG_EN is defined, otherwise the tied-off channel is checked.
module tb_regf_write_ctrl;

`ifdef REGF_DBG_EN
    localparam bit DbgOn = 1'b1;
`else
    localparam bit DbgOn = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        core_we;
    logic [4:0]  core_a3;
    logic [31:0] core_wd3;
    logic        core_stall, init_done;
    logic        dbg_valid, dbg_ready;
    logic [4:0]  dbg_addr;
    logic [31:0] dbg_data;
    logic        dbg_resp_valid, dbg_resp_err;
    logic        rf_we3;
    logic [4:0]  rf_a3;
    logic [31:0] rf_wd3;

    int pass_cnt = 0;
    int total_cnt = 0;

    typedef struct packed {
        logic [4:0]  a;
        logic [31:0] d;
    } wr_t;

    typedef struct {
        logic        we;
        logic [4:0]  a3;
        logic [31:0] wd;
        logic        exp_we;
    } vec_t;

    wr_t  wr_q[$];
    logic resp_q[$];
    wr_t  mon_e;
    logic mon_err;
    vec_t vecs[5];

    always #5 clk = ~clk;

    regf_write_ctrl #(
        .XLEN       (32),
        .AW         (5),
        .STARVE_MAX (8)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .core_we        (core_we),
        .core_a3        (core_a3),
        .core_wd3       (core_wd3),
        .core_stall     (core_stall),
        .init_done      (init_done),
        .dbg_valid      (dbg_valid),
        .dbg_ready      (dbg_ready),
        .dbg_addr       (dbg_addr),
        .dbg_data       (dbg_data),
        .dbg_resp_valid (dbg_resp_valid),
        .dbg_resp_err   (dbg_resp_err),
        .rf_we3         (rf_we3),
        .rf_a3          (rf_a3),
        .rf_wd3         (rf_wd3)
    );

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        total_cnt++;
        if (got === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic exp_wr(input logic [4:0] a, input logic [31:0] d);
        wr_q.push_back({a, d});
    endtask

    task automatic push_clear();
        for (int i = 1; i < 32; i++) exp_wr(5'(i), 32'h0);
    endtask

    // Every register-file write must match the next expected write.
    always @(negedge clk) begin
        if (rf_we3 !== 1'b0) begin
            if (wr_q.size() == 0) begin
                total_cnt++;
                $display("FAIL wr_unexpected: we3=%b a3=%0d wd3=%0h, none expected at %0t",
                         rf_we3, rf_a3, rf_wd3, $time);
            end else begin
                mon_e = wr_q.pop_front();
                chk("wr_addr", 32'(rf_a3), 32'(mon_e.a));
                chk("wr_data", rf_wd3, mon_e.d);
            end
        end
    end

    always @(negedge clk) begin
        if (dbg_resp_valid !== 1'b0) begin
            if (resp_q.size() == 0) begin
                total_cnt++;
                $display("FAIL resp_unexpected: valid=%b err=%b, none expected at %0t",
                         dbg_resp_valid, dbg_resp_err, $time);
            end else begin
                mon_err = resp_q.pop_front();
                chk("resp_err", 32'(dbg_resp_err), 32'(mon_err));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
        $fatal(1);
    end

    initial begin
        vecs[0] = '{we: 1'b1, a3: 5'd5,  wd: 32'hDEADBEEF, exp_we: 1'b1};
        vecs[1] = '{we: 1'b1, a3: 5'd0,  wd: 32'h11111111, exp_we: 1'b0};
        vecs[2] = '{we: 1'b0, a3: 5'd7,  wd: 32'h22222222, exp_we: 1'b0};
        vecs[3] = '{we: 1'b1, a3: 5'd31, wd: 32'h0000A5A5, exp_we: 1'b1};
        vecs[4] = '{we: 1'b1, a3: 5'd1,  wd: 32'hFFFFFFFF, exp_we: 1'b1};

        rst_n = 1'b0; core_we = 1'b0; core_a3 = '0; core_wd3 = '0;
        dbg_valid = 1'b0; dbg_addr = '0; dbg_data = '0;
        step(); step();
        @(negedge clk);
        chk("rst_we3", 32'(rf_we3), 32'(1'b0));
        chk("rst_stall", 32'(core_stall), 32'(1'b1));
        chk("rst_ready", 32'(dbg_ready), 32'(1'b0));
        chk("rst_resp_valid", 32'(dbg_resp_valid), 32'(1'b0));
        chk("rst_init_done", 32'(init_done), 32'(1'b0));

        // Clear interrupted by a reset pulse while index 12 is on the port.
        step();
        rst_n = 1'b1;
        for (int i = 1; i < 12; i++) exp_wr(5'(i), 32'h0);
        for (int i = 0; i < 11; i++) step();
        rst_n = 1'b0;
        @(negedge clk);
        chk("midclear_rst_we3", 32'(rf_we3), 32'(1'b0));
        step();
        rst_n = 1'b1;
        push_clear();
        for (int i = 0; i < 31; i++) begin
            @(negedge clk);
            chk("init_stall", 32'(core_stall), 32'(1'b1));
            chk("init_done_low", 32'(init_done), 32'(1'b0));
            step();
        end
        @(negedge clk);
        chk("init_done_high", 32'(init_done), 32'(1'b1));
        chk("run_stall", 32'(core_stall), 32'(1'b0));

        // Core pass-through vectors; debug valid is only driven when tied off.
        for (int i = 0; i < 5; i++) begin
            step();
            core_we   = vecs[i].we;
            core_a3   = vecs[i].a3;
            core_wd3  = vecs[i].wd;
            dbg_valid = !DbgOn;
            dbg_addr  = 5'd4;
            if (vecs[i].exp_we) exp_wr(vecs[i].a3, vecs[i].wd);
            @(negedge clk);
            chk("pt_we3", 32'(rf_we3), 32'(vecs[i].exp_we));
            chk("pt_stall", 32'(core_stall), 32'(1'b0));
            chk("pt_ready", 32'(dbg_ready), 32'(DbgOn));
        end
        step();
        core_we = 1'b0; dbg_valid = 1'b0;

`ifdef REGF_DBG_EN
        // Idle core: accept, drain next cycle, clean response after that.
        dbg_valid = 1'b1; dbg_addr = 5'd7; dbg_data = 32'h1234;
        exp_wr(5'd7, 32'h1234);
        resp_q.push_back(1'b0);
        @(negedge clk);
        chk("a_ready", 32'(dbg_ready), 32'(1'b1));
        step();
        dbg_valid = 1'b0;
        @(negedge clk);
        chk("a_drain_we3", 32'(rf_we3), 32'(1'b1));
        chk("a_drain_a3", 32'(rf_a3), 32'(5'd7));
        chk("a_busy_ready", 32'(dbg_ready), 32'(1'b0));
        chk("a_resp_early", 32'(dbg_resp_valid), 32'(1'b0));
        step();
        @(negedge clk);
        chk("a_resp_valid", 32'(dbg_resp_valid), 32'(1'b1));
        step();

        // Core write to the buffered address discards the debug write.
        dbg_valid = 1'b1; dbg_addr = 5'd9; dbg_data = 32'h99;
        resp_q.push_back(1'b1);
        step();
        dbg_valid = 1'b0;
        core_we = 1'b1; core_a3 = 5'd9; core_wd3 = 32'h5555;
        exp_wr(5'd9, 32'h5555);
        @(negedge clk);
        chk("b_core_wins", rf_wd3, 32'h5555);
        step();
        core_we = 1'b0;
        @(negedge clk);
        chk("b_resp_valid", 32'(dbg_resp_valid), 32'(1'b1));
        chk("b_no_late_wr", 32'(rf_we3), 32'(1'b0));
        step();

        // Address zero is refused with an error and never written.
        dbg_valid = 1'b1; dbg_addr = 5'd0; dbg_data = 32'hEEEE;
        resp_q.push_back(1'b1);
        step();
        dbg_valid = 1'b0;
        @(negedge clk);
        chk("c_resp_valid", 32'(dbg_resp_valid), 32'(1'b1));
        chk("c_ready", 32'(dbg_ready), 32'(1'b1));
        step();

        // Core busy every cycle: buffer is forced out on the 9th cycle.
        core_we = 1'b1; core_a3 = 5'd20; core_wd3 = 32'h100;
        dbg_valid = 1'b1; dbg_addr = 5'd3; dbg_data = 32'hC0FFEE;
        exp_wr(5'd20, 32'h100);
        resp_q.push_back(1'b0);
        step();
        dbg_valid = 1'b0;
        for (int k = 0; k < 9; k++) begin
            core_wd3 = 32'h200 + 32'(k);
            if (k < 8) exp_wr(5'd20, core_wd3);
            else exp_wr(5'd3, 32'hC0FFEE);
            @(negedge clk);
            chk("d_stall", 32'(core_stall), 32'(k == 8));
            step();
        end
        core_we = 1'b0;
        @(negedge clk);
        chk("d_resp_valid", 32'(dbg_resp_valid), 32'(1'b1));
        step();

        // Reset with a pending write: it is lost and nothing responds.
        core_we = 1'b1; core_a3 = 5'd20; core_wd3 = 32'h300;
        dbg_valid = 1'b1; dbg_addr = 5'd15; dbg_data = 32'hBAD;
        exp_wr(5'd20, 32'h300);
        step();
        dbg_valid = 1'b0; core_wd3 = 32'h301;
        exp_wr(5'd20, 32'h301);
        @(negedge clk);
        chk("e_full_ready", 32'(dbg_ready), 32'(1'b0));
        step();
        rst_n = 1'b0; core_we = 1'b0;
        step(); step();
        rst_n = 1'b1;
        push_clear();
        for (int i = 0; i < 31; i++) step();
        @(negedge clk);
        chk("e_init_done", 32'(init_done), 32'(1'b1));
        step();
`else
        // Tied-off channel never handshakes, whatever the request.
        dbg_valid = 1'b1; dbg_addr = 5'd4; dbg_data = 32'h44;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("nd_ready", 32'(dbg_ready), 32'(1'b0));
            chk("nd_we3", 32'(rf_we3), 32'(1'b0));
            step();
        end
        dbg_valid = 1'b0;
`endif

        step(); step();
        chk("wr_q_empty", 32'(wr_q.size()), 32'(0));
        chk("resp_q_empty", 32'(resp_q.size()), 32'(0));
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
